mux_rr: RTL
===========

# mux_rr

Parametrised N-channel selector for the Banco A datapath. It is the registered successor of the bank's 14-way, 16-bit combinational output mux. It adds per-channel valid/ready handshakes, a one-entry output register with backpressure, and two selection modes: direct (`sel`-driven) and round-robin arbitration across requesting channels. It sits between the register-bank read ports and the downstream consumer, so bank outputs can be drained in order without the consumer driving `sel`.

## Interface
- `WIDTH`, 16: data width per channel.
- `N`, 14: channel count; legal range 2..16.
- `SEL_W`, 4: width of `sel` and `out_ch`; must satisfy 2^SEL_W >= N.

- `clk`  in  1  : single clock; all state updates on rising edge.
- `rst`  in  1  : reset, synchronous and active-high.
- `in_bus`  in  N*WIDTH  : packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  N  : per-channel request; bit k qualifies channel k.
- `in_ready`  out  N  : per-channel accept, one-hot or zero, combinational.
- `mode`  in  1  : 0 = direct select, 1 = round-robin.
- `sel`  in  SEL_W  : channel index in direct mode; ignored in round-robin mode.
- `out_data`  out  WIDTH  : registered selected data.
- `out_valid`  out  1  : output register holds a word.
- `out_ready`  in  1  : consumer accepts `out_data` this cycle.
- `out_ch`  out  SEL_W  : index of the channel that produced `out_data`.

## Operation
- Output register state: `out_data`, `out_valid`, `out_ch`. Arbitration pointer `last` (SEL_W bits) holds the last captured channel.
- `load_en` = !out_valid || out_ready. A full register that is being drained can refill in the same cycle.
- Candidate selection, combinational:
  - Direct mode (`mode`=0): candidate = `sel` if `sel` < N and `in_valid[sel]`=1. Otherwise there is no candidate. An out-of-range `sel` never captures, which replaces the old default-zero output.
  - Round-robin mode (`mode`=1): search from (`last`+1) mod N upward, wrapping. The candidate is the first index with `in_valid` set. If `in_valid`=0, there is no candidate.
- Capture = `load_en` and a candidate exists. `in_ready[candidate]`=1 in that cycle, and all other bits are 0. With no capture, `in_ready`=0.
- On capture: `out_data` <= channel data, `out_ch` <= candidate, `out_valid` <= 1, `last` <= candidate. `last` updates in both modes.
- On `out_ready` with no capture: `out_valid` <= 0. `out_data` and `out_ch` hold their last value.
- While `out_valid`=1 and `out_ready`=0: all outputs hold, `in_ready`=0, and input changes have no effect.
- A `mode` or `sel` change takes effect on the next candidate evaluation. It never alters a word already held.
- Reset: `out_data`=0, `out_valid`=0, `out_ch`=0, `last`=N-1, so the first round-robin search starts at channel 0. Reset overrides any capture in the same cycle and discards a held word.

## Timing
- Latency: a channel accepted in cycle t appears on `out_data`/`out_valid` in cycle t+1.
- Throughput: one word per cycle while `out_ready`=1 and a candidate exists.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_valid` and `out_ready`. It has no dependence on `in_bus`.
- Round-robin fairness: with all N channels requesting continuously and `out_ready`=1, each channel is granted exactly once per N consecutive captures.
- A transfer on an input channel occurs only when `in_valid[k]` and `in_ready[k]` are both 1 on the same edge. A transfer on the output occurs only when `out_valid` and `out_ready` are both 1 on the same edge.

## Test plan
- Reset: assert `rst` for 2 cycles with every `in_valid` set. Required: `out_valid`=0, `out_data`=0x0000, `out_ch`=0 and `in_ready`=0 during reset. The first round-robin grant after reset goes to channel 0.
- Direct mode: `mode`=0, `sel`=5, channel 5 data=0xA5A5 and valid, `out_ready`=1. Required: `in_ready`=0x0020, then next cycle `out_data`=0xA5A5 and `out_ch`=5. With `sel`=14 or 15 (N=14), `in_ready`=0 and `out_valid` falls.
- Round-robin sweep: `mode`=1, all valid, channel k data=0x1000+k, `out_ready`=1. Required: `out_ch` sequence 0,1,…,13,0 on consecutive cycles.
- Sparse requests with wrap: `in_valid` bits 2, 9 and 13 set, `last`=9. Required grant order 13, 2, 9, 13.
- Backpressure: with `out_valid`=1, hold `out_ready`=0 for 4 cycles while changing `in_bus`/`sel`. Required: `out_data` and `out_ch` stable and `in_ready`=0. On the cycle `out_ready`=1, a new capture loads with no bubble.
- Mid-operation reset: assert `rst` while `out_valid`=1 and `out_ready`=0. Required: the next cycle shows `out_valid`=0, and round-robin resumes at channel 0.

Source files
------------

// File: rtl/mux_rr_if.sv
// rtl/mux_rr_if.sv - channel request and output handshake bundle for mux_rr
interface mux_rr_if #(
  parameter int WIDTH = 16,
  parameter int N     = 14,
  parameter int SEL_W = 4
);
  logic [N*WIDTH-1:0] in_bus;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_ch;

  modport master (
    output in_bus, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_bus, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_rr.sv
// rtl/mux_rr.sv - N-channel registered selector with direct and round-robin modes
module mux_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 14,
  parameter int SEL_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  mux_rr_if.slave  bus
);
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] cand;
  logic             have_cand;
  logic             load_en;
  logic             capture;
  logic [N-1:0]     ready;
  int               idx;

  assign load_en = !bus.out_valid || bus.out_ready;
  // Reset gating keeps in_ready low while the register is being cleared.
  assign capture = !rst && load_en && have_cand;

  always_comb begin
    have_cand = 1'b0;
    cand      = '0;
    idx       = 0;
    if (!bus.mode) begin
      for (int k = 0; k < N; k++) begin
        if (int'(bus.sel) == k && bus.in_valid[k]) begin
          have_cand = 1'b1;
          cand      = SEL_W'(k);
        end
      end
    end else begin
      // Walk offsets farthest-first so the nearest requester after last wins.
      for (int off = N; off >= 1; off--) begin
        idx = (int'(last) + off) % N;
        if (bus.in_valid[idx]) begin
          have_cand = 1'b1;
          cand      = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int k = 0; k < N; k++) begin
      ready[k] = capture && (int'(cand) == k);
    end
  end

  assign bus.in_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      last          <= SEL_W'(N - 1);
    end else if (capture) begin
      bus.out_data  <= bus.in_bus[int'(cand)*WIDTH +: WIDTH];
      bus.out_valid <= 1'b1;
      bus.out_ch    <= cand;
      last          <= cand;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
